// File: rtl/func_unit_scheduler_pkg.sv
// Shared types and default sizes for the functional-unit scheduler.
// FUNC_SCHED_FLUSH_EN adds the flush input to func_unit_scheduler.
package func_unit_scheduler_pkg;

   localparam int NUM_FUNC_UNITS    = 5;
   localparam int FUNC_UNIT_OP_SIZE = 3;
   localparam int FU_LAT_SIZE       = 4;
   localparam int FU_ROB_ID_SIZE    = 4;
   localparam int FU_DATA_WIDTH     = 32;

   typedef enum logic [1:0] {
      FU_IDLE = 2'd0,
      FU_BUSY = 2'd1,
      FU_DONE = 2'd2
   } fu_state_e;

   // Round-robin successor with wrap at n.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/func_unit_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter; the pointer register lives in the parent.
// Grants the first request at or after ptr, wrapping to index 0.
module rr_arbiter #(
   parameter int N  = 5,
   parameter int IW = 3
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          any
);

   logic [N-1:0] req_hi;
   logic [N-1:0] req_lo;

   always_comb begin
      req_hi = '0;
      req_lo = '0;
      for (int i = 0; i < N; i++) begin
         if (i >= int'(ptr)) req_hi[i] = req[i];
         else                req_lo[i] = req[i];
      end
   end

   // Upper half (>= ptr) has priority, then the wrapped lower half.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!any && req_hi[i]) begin
            any     = 1'b1;
            gnt[i]  = 1'b1;
            gnt_idx = IW'(i);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!any && req_lo[i]) begin
            any     = 1'b1;
            gnt[i]  = 1'b1;
            gnt_idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/func_unit_scheduler.sv
// Functional-unit occupancy tracker and writeback arbiter.
// Define FUNC_SCHED_FLUSH_EN to add the flush input.
module func_unit_scheduler
   import func_unit_scheduler_pkg::*;
#(
   parameter int NUM_UNITS    = NUM_FUNC_UNITS,
   parameter int UNIT_ID_SIZE = FUNC_UNIT_OP_SIZE,
   parameter int LAT_SIZE     = FU_LAT_SIZE,
   parameter int ROB_ID_SIZE  = FU_ROB_ID_SIZE,
   parameter int DATA_WIDTH   = FU_DATA_WIDTH
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          issue_valid,
   input  logic [UNIT_ID_SIZE-1:0]       issue_unit,
   input  logic [LAT_SIZE-1:0]           issue_latency,
   input  logic [ROB_ID_SIZE-1:0]        issue_rob_id,
   input  logic [NUM_UNITS*DATA_WIDTH-1:0] unit_result,
   input  logic                          wb_ready,
   output logic [NUM_UNITS-1:0]          free_units,
   output logic                          issue_err,
   output logic                          wb_valid,
   output logic [UNIT_ID_SIZE-1:0]       wb_unit,
   output logic [ROB_ID_SIZE-1:0]        wb_rob_id,
   output logic [DATA_WIDTH-1:0]         wb_data
`ifdef FUNC_SCHED_FLUSH_EN
   ,
   input  logic                          flush
`endif
);

   logic flush_act;

`ifdef FUNC_SCHED_FLUSH_EN
   assign flush_act = flush;
`else
   assign flush_act = 1'b0;
`endif

   fu_state_e               state_q [NUM_UNITS];
   fu_state_e               state_d [NUM_UNITS];
   logic [LAT_SIZE-1:0]     cnt_q   [NUM_UNITS];
   logic [LAT_SIZE-1:0]     cnt_d   [NUM_UNITS];
   logic [ROB_ID_SIZE-1:0]  rob_q   [NUM_UNITS];
   logic [ROB_ID_SIZE-1:0]  rob_d   [NUM_UNITS];

   logic [NUM_UNITS-1:0]    done_req;
   logic [NUM_UNITS-1:0]    issue_sel;
   logic [NUM_UNITS-1:0]    issue_take;
   logic                    issue_ok;
   logic [LAT_SIZE-1:0]     issue_lat;

   logic [UNIT_ID_SIZE-1:0] rr_ptr_q;
   logic [NUM_UNITS-1:0]    gnt;
   logic [UNIT_ID_SIZE-1:0] gnt_idx;
   logic                    gnt_any;
   logic                    grant_en;
   logic [NUM_UNITS-1:0]    gnt_fire;
   logic [ROB_ID_SIZE-1:0]  sel_rob;
   logic [DATA_WIDTH-1:0]   sel_data;

   // Out-of-range indices match no bit, so they are rejected here.
   always_comb begin
      issue_sel = '0;
      for (int i = 0; i < NUM_UNITS; i++)
         issue_sel[i] = (issue_unit == UNIT_ID_SIZE'(i));
   end

   assign issue_ok   = issue_valid && !flush_act
                    && |(issue_sel & free_units);
   assign issue_take = issue_sel & {NUM_UNITS{issue_ok}};
   assign issue_lat  = (issue_latency == '0) ? LAT_SIZE'(1)
                                             : issue_latency;

   assign grant_en = (!wb_valid || wb_ready) && !flush_act;
   assign gnt_fire = gnt & {NUM_UNITS{grant_en}};

   rr_arbiter #(
      .N  (NUM_UNITS),
      .IW (UNIT_ID_SIZE)
   ) u_arb (
      .req     (done_req),
      .ptr     (rr_ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any     (gnt_any)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_UNITS; i++) begin
            state_q[i] <= FU_IDLE;
            cnt_q[i]   <= '0;
            rob_q[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_UNITS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
            rob_q[i]   <= rob_d[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_UNITS; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         rob_d[i]   = rob_q[i];
         unique case (state_q[i])
            FU_IDLE: begin
               if (issue_take[i]) begin
                  state_d[i] = FU_BUSY;
                  cnt_d[i]   = issue_lat;
                  rob_d[i]   = issue_rob_id;
               end
            end
            FU_BUSY: begin
               cnt_d[i] = cnt_q[i] - LAT_SIZE'(1);
               if (cnt_q[i] == LAT_SIZE'(1))
                  state_d[i] = FU_DONE;
            end
            FU_DONE: begin
               if (gnt_fire[i])
                  state_d[i] = FU_IDLE;
            end
            default: state_d[i] = FU_IDLE;
         endcase
         if (flush_act)
            state_d[i] = FU_IDLE;
      end
   end

   always_comb begin
      free_units = '0;
      done_req   = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         free_units[i] = (state_q[i] == FU_IDLE);
         done_req[i]   = (state_q[i] == FU_DONE);
      end
   end

   always_comb begin
      sel_rob  = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (gnt[i]) begin
            sel_rob  = sel_rob | rob_q[i];
            sel_data = sel_data
                     | unit_result[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // A stalled beat (valid && !ready) keeps every wb_* field frozen.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_valid  <= 1'b0;
         wb_unit   <= '0;
         wb_rob_id <= '0;
         wb_data   <= '0;
         rr_ptr_q  <= '0;
      end else if (flush_act) begin
         wb_valid  <= 1'b0;
         rr_ptr_q  <= '0;
      end else if (grant_en) begin
         if (gnt_any) begin
            wb_valid  <= 1'b1;
            wb_unit   <= gnt_idx;
            wb_rob_id <= sel_rob;
            wb_data   <= sel_data;
            rr_ptr_q  <= UNIT_ID_SIZE'(
               rr_next(int'(gnt_idx), NUM_UNITS));
         end else begin
            wb_valid  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         issue_err <= 1'b0;
      else
         issue_err <= issue_valid && !issue_ok && !flush_act;
   end

endmodule

// File: tb/tb_func_unit_scheduler.sv
// Randomized bench for func_unit_scheduler against a cycle-level model.
// Build with FUNC_SCHED_FLUSH_EN to also exercise flush.
module tb_func_unit_scheduler;

   localparam int N  = 5;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic            issue_valid;
   logic [2:0]      issue_unit;
   logic [3:0]      issue_latency;
   logic [3:0]      issue_rob_id;
   logic [N*DW-1:0] unit_result;
   logic            wb_ready;
   logic [N-1:0]    free_units;
   logic            issue_err;
   logic            wb_valid;
   logic [2:0]      wb_unit;
   logic [3:0]      wb_rob_id;
   logic [DW-1:0]   wb_data;
`ifdef FUNC_SCHED_FLUSH_EN
   logic            flush;
`endif

   func_unit_scheduler dut (
      .clk           (clk),
      .reset         (reset),
      .issue_valid   (issue_valid),
      .issue_unit    (issue_unit),
      .issue_latency (issue_latency),
      .issue_rob_id  (issue_rob_id),
      .unit_result   (unit_result),
      .wb_ready      (wb_ready),
      .free_units    (free_units),
      .issue_err     (issue_err),
      .wb_valid      (wb_valid),
      .wb_unit       (wb_unit),
      .wb_rob_id     (wb_rob_id),
      .wb_data       (wb_data)
`ifdef FUNC_SCHED_FLUSH_EN
      ,
      .flush         (flush)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Model: a unit is occupied from issue until granted; it is
   // complete (eligible for grant) once the edge ready_at has passed.
   bit          m_occ [N];
   int          m_rdy [N];
   logic [3:0]  m_rob [N];
   int          m_ptr;
   bit          m_wbv;
   int          m_wbu;
   logic [3:0]  m_wbr;
   logic [31:0] m_wbd;
   bit          m_err;
   int          edge_no;

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_occ[i] = 0;
         m_rdy[i] = 0;
         m_rob[i] = '0;
      end
      m_ptr = 0;
      m_wbv = 0;
      m_wbu = 0;
      m_wbr = '0;
      m_wbd = '0;
      m_err = 0;
   endtask

   task automatic check_all(input string where);
      logic [N-1:0] exp_free;
      for (int i = 0; i < N; i++) exp_free[i] = !m_occ[i];
      chk({where, ".free"}, 64'(free_units), 64'(exp_free));
      chk({where, ".err"},  64'(issue_err),  64'(m_err));
      chk({where, ".wbv"},  64'(wb_valid),   64'(m_wbv));
      chk({where, ".unit"}, 64'(wb_unit),    64'(m_wbu));
      chk({where, ".rob"},  64'(wb_rob_id),  64'(m_wbr));
      chk({where, ".data"}, 64'(wb_data),    64'(m_wbd));
   endtask

   task automatic idle_inputs();
      issue_valid   = 0;
      issue_unit    = '0;
      issue_latency = '0;
      issue_rob_id  = '0;
      wb_ready      = 1;
`ifdef FUNC_SCHED_FLUSH_EN
      flush         = 0;
`endif
   endtask

   task automatic step(input bit v, input int u, input int lat,
                       input int rob, input bit wr, input bit fl,
                       input string where);
      bit done_pre [N];
      bit free_pre [N];
      bit acc;
      int win;
      issue_valid   = v;
      issue_unit    = 3'(u);
      issue_latency = 4'(lat);
      issue_rob_id  = 4'(rob);
      wb_ready      = wr;
`ifdef FUNC_SCHED_FLUSH_EN
      flush         = fl;
`endif
      for (int i = 0; i < N; i++)
         unit_result[i*DW +: DW] = $urandom;
      for (int i = 0; i < N; i++) begin
         free_pre[i] = !m_occ[i];
         done_pre[i] = m_occ[i] && (m_rdy[i] <= edge_no - 1);
      end
`ifdef FUNC_SCHED_FLUSH_EN
      if (fl) begin
         for (int i = 0; i < N; i++) m_occ[i] = 0;
         m_wbv = 0;
         m_ptr = 0;
         m_err = 0;
      end else begin
`else
      begin
`endif
         if (!m_wbv || wr) begin
            win = -1;
            for (int k = 0; k < N; k++)
               if (win < 0 && done_pre[(m_ptr + k) % N])
                  win = (m_ptr + k) % N;
            if (win >= 0) begin
               m_wbv = 1;
               m_wbu = win;
               m_wbr = m_rob[win];
               m_wbd = unit_result[win*DW +: DW];
               m_occ[win] = 0;
               m_ptr = (win + 1) % N;
            end else begin
               m_wbv = 0;
            end
         end
         acc = v && (u < N) && free_pre[u % N];
         if (acc) begin
            m_occ[u] = 1;
            m_rdy[u] = edge_no + ((lat == 0) ? 1 : lat);
            m_rob[u] = 4'(rob);
         end
         m_err = v && !acc;
      end
      @(posedge clk);
      edge_no++;
      #1;
      check_all(where);
   endtask

   task automatic rand_steps(input int n, input string where);
      bit fl;
      for (int s = 0; s < n; s++) begin
         fl = 0;
`ifdef FUNC_SCHED_FLUSH_EN
         fl = ($urandom_range(0, 63) == 0);
`endif
         step($urandom_range(0, 1) == 1,
              int'($urandom_range(0, 7)),
              int'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)),
              $urandom_range(0, 3) != 0,
              fl, where);
      end
   endtask

   task automatic do_reset(input string where);
      idle_inputs();
      reset = 0;
      model_reset();
      #1;
      check_all(where);
      #3;
      reset = 1;
      @(posedge clk);
      edge_no++;
      #1;
      check_all({where, "_rel"});
   endtask

   initial begin
      idle_inputs();
      unit_result = '0;
      edge_no = 0;
      reset = 1;
      #2;
      do_reset("reset");

      step(1, 2, 3, 7, 1, 0, "lat3");
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0, "lat3");

      step(1, 3, 9, 5, 1, 0, "busy_issue");
      step(1, 3, 2, 1, 1, 0, "to_busy");
      step(1, 6, 2, 1, 1, 0, "range6");
      step(1, 7, 2, 1, 1, 0, "range7");
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 0, "drain");

      step(1, 0, 3, 10, 1, 0, "tri");
      step(1, 1, 2, 11, 1, 0, "tri");
      step(1, 4, 1, 12, 1, 0, "tri");
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 0, "tri");

      step(1, 0, 1, 3, 0, 0, "stall");
      step(1, 2, 1, 4, 0, 0, "stall");
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, "stall");
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, "unstall");

      step(1, 1, 0, 9, 1, 0, "lat0");
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, "lat0");

      rand_steps(3000, "rand");

      for (int i = 0; i < N; i++)
         step(1, i, 2 + 2 * i, i, 0, 0, "pre_rst");
      step(0, 0, 0, 0, 0, 0, "pre_rst");
      #3;
      do_reset("mid_reset");

      rand_steps(1500, "rand2");

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
